// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, opsel encodings and sequencer states.
package alu_pkg;
   localparam int DWIDTH = 32;
   localparam int OPSELW = 3;

   localparam logic [OPSELW-1:0] ALU_ADD = 3'd0;
   localparam logic [OPSELW-1:0] ALU_SUB = 3'd1;
   localparam logic [OPSELW-1:0] ALU_AND = 3'd2;
   localparam logic [OPSELW-1:0] ALU_OR  = 3'd3;
   localparam logic [OPSELW-1:0] ALU_XOR = 3'd4;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} seq_state_t;
endpackage

// File: rtl/alu_flag_gen.sv
// Derives carry/zero/sign flags from a raw ALU result.
module alu_flag_gen #(
   parameter int DWIDTH = 32
) (
   input  logic [DWIDTH-1:0] result,
   input  logic              cout,
   output logic              c,
   output logic              z,
   output logic              s
);
   assign c = cout;
   assign z = (result == '0);
   assign s = result[DWIDTH-1];
endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the bit-sliced ALU: one request in, one EXEC cycle, response held
// until accepted. A carry register lets add/sub chains span multiple requests.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DWIDTH = alu_pkg::DWIDTH,
   parameter int OPSELW = alu_pkg::OPSELW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DWIDTH-1:0] req_op1,
   input  logic [DWIDTH-1:0] req_op2,
   input  logic [OPSELW-1:0] req_opsel,
   input  logic              req_mode,
   input  logic              req_chain,
   input  logic              req_cin,
   output logic [DWIDTH-1:0] alu_op1,
   output logic [DWIDTH-1:0] alu_op2,
   output logic [OPSELW-1:0] alu_opsel,
   output logic              alu_mode,
   output logic              alu_cin,
   input  logic [DWIDTH-1:0] alu_result,
   input  logic              alu_cout,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_result,
   output logic              rsp_c,
   output logic              rsp_z,
   output logic              rsp_s
);
   seq_state_t state, state_nxt;
   logic       carry_q;
   logic       flag_c, flag_z, flag_s;

   alu_flag_gen #(.DWIDTH(DWIDTH)) u_flags (
      .result (alu_result),
      .cout   (alu_cout),
      .c      (flag_c),
      .z      (flag_z),
      .s      (flag_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // alu_* stay at the last issued op outside EXEC; only the EXEC cycle is meaningful.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_op1    <= '0;
         alu_op2    <= '0;
         alu_opsel  <= '0;
         alu_mode   <= 1'b0;
         alu_cin    <= 1'b0;
         carry_q    <= 1'b0;
         rsp_result <= '0;
         rsp_c      <= 1'b0;
         rsp_z      <= 1'b0;
         rsp_s      <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            alu_op1   <= req_op1;
            alu_op2   <= req_op2;
            alu_opsel <= req_opsel;
            alu_mode  <= req_mode;
            alu_cin   <= req_chain ? carry_q : req_cin;
         end
         if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_c      <= flag_c;
            rsp_z      <= flag_z;
            rsp_s      <= flag_s;
            carry_q    <= alu_cout;
         end
      end
   end
endmodule
